// File: rtl/nmr_bstrm_dpath_ser.sv
// Datapath serializer: double-buffers sequencer command words and emits them as a gapless 1-bit stream.
// Optional build macro BSTRM_MSB_FIRST_EN: pattern words shift MSB first instead of LSB first.
module nmr_bstrm_dpath_ser #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DUR_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DPATH_START,
  output logic                  DPATH_BUF_RDY,
  input  logic [DATA_WIDTH-1:0] data_reg,
  input  logic                  seq_end_reg,
  input  logic                  all_1s_mode_reg,
  input  logic                  all_0s_mode_reg,
  input  logic                  CLR_FLAGS,
  output logic                  BSTRM_OUT,
  output logic                  BSTRM_VALID,
  output logic                  SEQ_DONE,
  output logic                  OVERRUN,
  output logic                  UNDERRUN
);

  localparam int unsigned BCW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;
  typedef enum logic [1:0] {K_PAT, K_ONES, K_ZEROS} kind_t;

  state_t                state_q, state_d;
  logic                  hold_full_q, hold_full_d;
  logic                  hold_seq_q, hold_seq_d;
  kind_t                 hold_kind_q, hold_kind_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  pend_q, pend_d;
  kind_t                 sh_kind_q, sh_kind_d;
  logic [DATA_WIDTH-1:0] sh_data_q, sh_data_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DUR_WIDTH-1:0]  run_cnt_q, run_cnt_d;
  logic                  out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  rdy_q, rdy_d;
  logic                  ovr_q, ovr_d;
  logic                  und_q, und_d;

  logic                  take_c, load_c, last_c, capture_c, hold_free_c;
  logic                  ovr_set_c, und_set_c;
  kind_t                 in_kind_c;
  logic [DUR_WIDTH-1:0]  hold_len_c;

  // Mode decode: seq_end is handled separately; all_0s outranks all_1s
  always_comb begin
    in_kind_c = K_PAT;
    if (all_0s_mode_reg)      in_kind_c = K_ZEROS;
    else if (all_1s_mode_reg) in_kind_c = K_ONES;
  end

  assign hold_len_c = hold_data_q[DUR_WIDTH-1:0];
  assign last_c     = (sh_kind_q == K_PAT) ? (bit_cnt_q == '0) : (run_cnt_q == '0);

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_seq_d  = hold_seq_q;
    hold_kind_d = hold_kind_q;
    hold_data_d = hold_data_q;
    pend_d      = pend_q;
    sh_kind_d   = sh_kind_q;
    sh_data_d   = sh_data_q;
    bit_cnt_d   = bit_cnt_q;
    run_cnt_d   = run_cnt_q;
    out_d       = 1'b0;
    valid_d     = 1'b0;
    take_c      = 1'b0;
    load_c      = 1'b0;
    ovr_set_c   = 1'b0;
    und_set_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          take_c = 1'b1;
          if (hold_seq_q) state_d = S_END;
          else begin
            load_c  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (last_c) begin
          if (hold_full_q && !hold_seq_q) begin
            load_c = 1'b1;
            take_c = 1'b1;
          end else if (hold_full_q) begin
            take_c  = 1'b1;
            state_d = S_END;
          end else begin
            und_set_c = 1'b1;
            state_d   = S_IDLE;
          end
        end else begin
          valid_d = 1'b1;
          if (sh_kind_q == K_PAT) begin
`ifdef BSTRM_MSB_FIRST_EN
            out_d     = sh_data_q[DATA_WIDTH-1];
            sh_data_d = sh_data_q << 1;
`else
            out_d     = sh_data_q[0];
            sh_data_d = sh_data_q >> 1;
`endif
            bit_cnt_d = bit_cnt_q - BCW'(1);
          end else begin
            out_d     = (sh_kind_q == K_ONES);
            run_cnt_d = run_cnt_q - DUR_WIDTH'(1);
          end
        end
      end
      S_END: ;
      default: state_d = S_IDLE;
    endcase

    // Shifter load presents the first bit on the same edge
    if (load_c) begin
      sh_kind_d = hold_kind_q;
      valid_d   = 1'b1;
      bit_cnt_d = BCW'(DATA_WIDTH - 1);
      run_cnt_d = (hold_len_c == '0) ? '0 : hold_len_c - DUR_WIDTH'(1);
      if (hold_kind_q == K_PAT) begin
`ifdef BSTRM_MSB_FIRST_EN
        out_d     = hold_data_q[DATA_WIDTH-1];
        sh_data_d = hold_data_q << 1;
`else
        out_d     = hold_data_q[0];
        sh_data_d = hold_data_q >> 1;
`endif
      end else begin
        out_d = (hold_kind_q == K_ONES);
      end
    end

    // Holding register: a slot freed this edge can be refilled on the same edge
    if (take_c) hold_full_d = 1'b0;
    hold_free_c = !hold_full_q || take_c;
    capture_c   = hold_free_c && (pend_q || DPATH_START);
    if (DPATH_START && pend_q) ovr_set_c = 1'b1;
    if (capture_c) begin
      hold_full_d = 1'b1;
      hold_seq_d  = seq_end_reg;
      hold_kind_d = in_kind_c;
      hold_data_d = data_reg;
      pend_d      = 1'b0;
      if (state_q == S_END) state_d = S_IDLE;
    end else if (DPATH_START && !pend_q) begin
      pend_d = 1'b1;
    end

    rdy_d  = !pend_d && !hold_full_d && !DPATH_START;
    done_d = (state_d == S_END);
    ovr_d  = CLR_FLAGS ? 1'b0 : (ovr_q || ovr_set_c);
    und_d  = CLR_FLAGS ? 1'b0 : (und_q || und_set_c);
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      hold_full_q <= 1'b0;
      hold_seq_q  <= 1'b0;
      hold_kind_q <= K_PAT;
      hold_data_q <= '0;
      pend_q      <= 1'b0;
      sh_kind_q   <= K_PAT;
      sh_data_q   <= '0;
      bit_cnt_q   <= '0;
      run_cnt_q   <= '0;
      out_q       <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      rdy_q       <= 1'b1;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_seq_q  <= hold_seq_d;
      hold_kind_q <= hold_kind_d;
      hold_data_q <= hold_data_d;
      pend_q      <= pend_d;
      sh_kind_q   <= sh_kind_d;
      sh_data_q   <= sh_data_d;
      bit_cnt_q   <= bit_cnt_d;
      run_cnt_q   <= run_cnt_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      rdy_q       <= rdy_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
    end
  end

  assign DPATH_BUF_RDY = rdy_q;
  assign BSTRM_OUT     = out_q;
  assign BSTRM_VALID   = valid_q;
  assign SEQ_DONE      = done_q;
  assign OVERRUN       = ovr_q;
  assign UNDERRUN      = und_q;

endmodule

// File: tb/tb_nmr_bstrm_dpath_ser.sv
// Directed bench for nmr_bstrm_dpath_ser at DATA_WIDTH=8, DUR_WIDTH=8.
module tb_nmr_bstrm_dpath_ser;

  logic       CLK;
  logic       RST;
  logic       DPATH_START;
  logic       DPATH_BUF_RDY;
  logic [7:0] data_reg;
  logic       seq_end_reg;
  logic       all_1s_mode_reg;
  logic       all_0s_mode_reg;
  logic       CLR_FLAGS;
  logic       BSTRM_OUT;
  logic       BSTRM_VALID;
  logic       SEQ_DONE;
  logic       OVERRUN;
  logic       UNDERRUN;

  int pass_cnt = 0;
  int total    = 0;

  nmr_bstrm_dpath_ser #(.DATA_WIDTH(8), .DUR_WIDTH(8)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .DPATH_START    (DPATH_START),
    .DPATH_BUF_RDY  (DPATH_BUF_RDY),
    .data_reg       (data_reg),
    .seq_end_reg    (seq_end_reg),
    .all_1s_mode_reg(all_1s_mode_reg),
    .all_0s_mode_reg(all_0s_mode_reg),
    .CLR_FLAGS      (CLR_FLAGS),
    .BSTRM_OUT      (BSTRM_OUT),
    .BSTRM_VALID    (BSTRM_VALID),
    .SEQ_DONE       (SEQ_DONE),
    .OVERRUN        (OVERRUN),
    .UNDERRUN       (UNDERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; DPATH_START = 1'b0; CLR_FLAGS = 1'b0;
    data_reg = 8'h00; seq_end_reg = 1'b0; all_1s_mode_reg = 1'b0; all_0s_mode_reg = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  // One-cycle START strobe with the given command held on the inputs afterwards
  task automatic drive_cmd(input logic [7:0] d, input logic se, input logic ones, input logic zeros);
    data_reg = d; seq_end_reg = se; all_1s_mode_reg = ones; all_0s_mode_reg = zeros;
    DPATH_START = 1'b1;
    tick();
    DPATH_START = 1'b0;
  endtask

  function automatic logic pat_bit(input logic [7:0] p, input int i);
`ifdef BSTRM_MSB_FIRST_EN
    return p[7-i];
`else
    return p[i];
`endif
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (DPATH_BUF_RDY !== 1'b1) $display("FAIL reset_rdy got=%b exp=1", DPATH_BUF_RDY); else pass_cnt++;
    total++; if (BSTRM_OUT !== 1'b0) $display("FAIL reset_out got=%b exp=0", BSTRM_OUT); else pass_cnt++;
    total++; if (BSTRM_VALID !== 1'b0) $display("FAIL reset_valid got=%b exp=0", BSTRM_VALID); else pass_cnt++;
    total++; if (SEQ_DONE !== 1'b0) $display("FAIL reset_done got=%b exp=0", SEQ_DONE); else pass_cnt++;
    total++; if (OVERRUN !== 1'b0) $display("FAIL reset_ovr got=%b exp=0", OVERRUN); else pass_cnt++;
    total++; if (UNDERRUN !== 1'b0) $display("FAIL reset_und got=%b exp=0", UNDERRUN); else pass_cnt++;
  endtask

  task automatic test_pattern();
    logic [7:0] p;
    p = 8'hA5;
    do_reset();
    drive_cmd(p, 1'b0, 1'b0, 1'b0);
    total++; if (DPATH_BUF_RDY !== 1'b0) $display("FAIL pat_rdy_busy got=%b exp=0", DPATH_BUF_RDY); else pass_cnt++;
    total++; if (BSTRM_VALID !== 1'b0) $display("FAIL pat_latency got=%b exp=0", BSTRM_VALID); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if ({BSTRM_VALID, BSTRM_OUT} !== {1'b1, pat_bit(p, i)})
        $display("FAIL pat_bit%0d got=%b%b exp=1%b", i, BSTRM_VALID, BSTRM_OUT, pat_bit(p, i));
      else pass_cnt++;
    end
    tick();
    total++; if (BSTRM_VALID !== 1'b0) $display("FAIL pat_end_valid got=%b exp=0", BSTRM_VALID); else pass_cnt++;
    total++; if (DPATH_BUF_RDY !== 1'b1) $display("FAIL pat_end_rdy got=%b exp=1", DPATH_BUF_RDY); else pass_cnt++;
    total++; if (UNDERRUN !== 1'b1) $display("FAIL pat_drain_und got=%b exp=1", UNDERRUN); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    exp = 8'b0001_1111;
    do_reset();
    drive_cmd(8'd5, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 1) drive_cmd(8'd3, 1'b0, 1'b0, 1'b1);
      else if (i > 1) tick();
      total++;
      if ({BSTRM_VALID, BSTRM_OUT} !== {1'b1, exp[i]})
        $display("FAIL b2b_bit%0d got=%b%b exp=1%b", i, BSTRM_VALID, BSTRM_OUT, exp[i]);
      else pass_cnt++;
    end
    total++; if (UNDERRUN !== 1'b0) $display("FAIL b2b_und got=%b exp=0", UNDERRUN); else pass_cnt++;
    tick();
    total++; if (BSTRM_VALID !== 1'b0) $display("FAIL b2b_end_valid got=%b exp=0", BSTRM_VALID); else pass_cnt++;
  endtask

  task automatic test_seq_end();
    int ones;
    do_reset();
    drive_cmd(8'hFF, 1'b0, 1'b0, 1'b0);
    tick();
    ones = (BSTRM_VALID && BSTRM_OUT) ? 1 : 0;
    drive_cmd(8'h00, 1'b1, 1'b0, 1'b0);
    if (BSTRM_VALID && BSTRM_OUT) ones++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (BSTRM_VALID && BSTRM_OUT) ones++;
    end
    total++; if (ones != 8) $display("FAIL seq_ones got=%0d exp=8", ones); else pass_cnt++;
    total++; if (SEQ_DONE !== 1'b0) $display("FAIL seq_done_early got=%b exp=0", SEQ_DONE); else pass_cnt++;
    tick();
    total++;
    if ({SEQ_DONE, BSTRM_OUT, BSTRM_VALID, DPATH_BUF_RDY} !== 4'b1001)
      $display("FAIL seq_done got=%b%b%b%b exp=1001", SEQ_DONE, BSTRM_OUT, BSTRM_VALID, DPATH_BUF_RDY);
    else pass_cnt++;
    total++; if (UNDERRUN !== 1'b0) $display("FAIL seq_und got=%b exp=0", UNDERRUN); else pass_cnt++;
    drive_cmd(8'h01, 1'b0, 1'b0, 1'b0);
    total++; if (SEQ_DONE !== 1'b0) $display("FAIL seq_restart_done got=%b exp=0", SEQ_DONE); else pass_cnt++;
    tick();
    total++; if (BSTRM_VALID !== 1'b1) $display("FAIL seq_restart_valid got=%b exp=1", BSTRM_VALID); else pass_cnt++;
  endtask

  task automatic test_seq_end_first();
    do_reset();
    drive_cmd(8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if ({SEQ_DONE, BSTRM_VALID, DPATH_BUF_RDY} !== 3'b101)
      $display("FAIL seqfirst got=%b%b%b exp=101", SEQ_DONE, BSTRM_VALID, DPATH_BUF_RDY);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    do_reset();
    drive_cmd(8'd0, 1'b0, 1'b1, 1'b0);
    tick();
    total++; if ({BSTRM_VALID, BSTRM_OUT} !== 2'b11) $display("FAIL zlen_bit got=%b%b exp=11", BSTRM_VALID, BSTRM_OUT); else pass_cnt++;
    tick();
    total++; if (BSTRM_VALID !== 1'b0) $display("FAIL zlen_end got=%b exp=0", BSTRM_VALID); else pass_cnt++;
  endtask

  task automatic test_flags();
    int vcnt, ones;
    do_reset();
    drive_cmd(8'd20, 1'b0, 1'b1, 1'b0);
    tick();
    drive_cmd(8'd2, 1'b0, 1'b0, 1'b1);
    drive_cmd(8'd3, 1'b0, 1'b1, 1'b0);
    total++; if (DPATH_BUF_RDY !== 1'b0) $display("FAIL flg_rdy_pend got=%b exp=0", DPATH_BUF_RDY); else pass_cnt++;
    total++; if (OVERRUN !== 1'b0) $display("FAIL flg_ovr_early got=%b exp=0", OVERRUN); else pass_cnt++;
    drive_cmd(8'd3, 1'b0, 1'b1, 1'b0);
    total++; if (OVERRUN !== 1'b1) $display("FAIL flg_ovr_set got=%b exp=1", OVERRUN); else pass_cnt++;
    CLR_FLAGS = 1'b1;
    drive_cmd(8'd3, 1'b0, 1'b1, 1'b0);
    CLR_FLAGS = 1'b0;
    total++; if (OVERRUN !== 1'b0) $display("FAIL flg_ovr_clr got=%b exp=0", OVERRUN); else pass_cnt++;
    vcnt = 5; ones = 5;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!BSTRM_VALID) break;
      vcnt++;
      if (BSTRM_OUT) ones++;
    end
    total++; if (vcnt != 25) $display("FAIL flg_valid_cnt got=%0d exp=25", vcnt); else pass_cnt++;
    total++; if (ones != 23) $display("FAIL flg_ones_cnt got=%0d exp=23", ones); else pass_cnt++;
    total++; if (UNDERRUN !== 1'b1) $display("FAIL flg_und got=%b exp=1", UNDERRUN); else pass_cnt++;
    total++; if (DPATH_BUF_RDY !== 1'b1) $display("FAIL flg_rdy_end got=%b exp=1", DPATH_BUF_RDY); else pass_cnt++;
    CLR_FLAGS = 1'b1;
    tick();
    CLR_FLAGS = 1'b0;
    total++; if (UNDERRUN !== 1'b0) $display("FAIL flg_und_clr got=%b exp=0", UNDERRUN); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] p;
    p = 8'hA5;
    do_reset();
    drive_cmd(p, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    total++;
    if ({BSTRM_VALID, BSTRM_OUT} !== {1'b1, pat_bit(p, 3)})
      $display("FAIL mrst_bit3 got=%b%b exp=1%b", BSTRM_VALID, BSTRM_OUT, pat_bit(p, 3));
    else pass_cnt++;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++;
    if ({BSTRM_OUT, BSTRM_VALID, DPATH_BUF_RDY} !== 3'b001)
      $display("FAIL mrst_abort got=%b%b%b exp=001", BSTRM_OUT, BSTRM_VALID, DPATH_BUF_RDY);
    else pass_cnt++;
  endtask

  initial begin
    RST = 1'b1; DPATH_START = 1'b0; CLR_FLAGS = 1'b0;
    data_reg = 8'h00; seq_end_reg = 1'b0; all_1s_mode_reg = 1'b0; all_0s_mode_reg = 1'b0;
    test_reset();
    test_pattern();
    test_back_to_back();
    test_seq_end();
    test_seq_end_first();
    test_zero_len();
    test_flags();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
